collision_probe: RTL and testbench

COLLISION_PROBE -- requirements
Module: collision_probe

---
 rtl/collision_probe_pkg.sv | 53 +++++
 rtl/collision_probe_probe_point.sv | 49 ++++
 rtl/collision_probe.sv | 190 +++++++++++++++++++
 tb/tb_collision_probe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_probe_pkg.sv
// collision_probe_pkg
// Level-wide constants for the playfield and tile codes, plus the helper
// that turns a raw tile-map answer into an effective tile class.
// No ports (package).
package collision_probe_pkg;

    // Tile codes as stored in the tile map
    typedef enum logic [2:0] {
        TILE_EMPTY = 3'd0,
        TILE_SOLID = 3'd1,
        TILE_SPIKE = 3'd2,
        TILE_GOAL  = 3'd3
    } tile_t;

    // Playfield geometry in pixels
    localparam int LEFT    = 144;
    localparam int TOP     = 35;
    localparam int FIELD_W = 640;
    localparam int FIELD_H = 480;
    localparam int TILE    = 32;
    localparam int COL_MAX = FIELD_W / TILE - 1;
    localparam int ROW_MAX = FIELD_H / TILE - 1;

    // Inclusive in-range window in 11-bit probe coordinates
    localparam logic [10:0] X_MIN = 11'(LEFT);
    localparam logic [10:0] X_MAX = 11'(LEFT + FIELD_W - 1);
    localparam logic [10:0] Y_MIN = 11'(TOP);
    localparam logic [10:0] Y_MAX = 11'(TOP + FIELD_H - 1);

    // Probe sequence: indices 0..5, last one is FR
    localparam logic [2:0] LAST_IDX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Anything outside the field behaves as a wall; undefined codes 4-7
    // are harmless background.
    function automatic tile_t decode_tile(input logic [2:0] code, input logic oor);
        tile_t t;
        if (oor) begin
            t = TILE_SOLID;
        end else if (code > 3'd3) begin
            t = TILE_EMPTY;
        end else begin
            t = tile_t'(code);
        end
        return t;
    endfunction

endpackage

// File: rtl/collision_probe_probe_point.sv
// probe_point
// Maps the latched player box origin and a probe index to the 11-bit pixel
// coordinate of that probe, and flags coordinates outside the playfield.
// Ports:
//   base_x_i, base_y_i : player box top-left (10 bits)
//   idx_i              : probe index 0..5 (TL,TR,BL,BR,FL,FR)
//   x_o, y_o           : probe coordinate (11 bits, never wraps)
//   oor_o              : coordinate lies outside the visible field
module probe_point
    import collision_probe_pkg::*;
#(
    parameter int PW = 32,
    parameter int PH = 32
) (
    input  logic [9:0]  base_x_i,
    input  logic [9:0]  base_y_i,
    input  logic [2:0]  idx_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic        oor_o
);

    localparam logic [10:0] DX_RIGHT  = 11'(PW - 1);
    localparam logic [10:0] DY_BOTTOM = 11'(PH - 1);
    localparam logic [10:0] DY_FOOT   = 11'(PH);

    logic [10:0] dx;
    logic [10:0] dy;

    always_comb begin
        dx = '0;
        dy = '0;
        case (idx_i)
            3'd1: dx = DX_RIGHT;
            3'd2: dy = DY_BOTTOM;
            3'd3: begin dx = DX_RIGHT; dy = DY_BOTTOM; end
            3'd4: dy = DY_FOOT;
            3'd5: begin dx = DX_RIGHT; dy = DY_FOOT; end
            default: begin dx = '0; dy = '0; end
        endcase
    end

    // 11-bit sums cannot overflow (1023 + PW stays below 2048), so anything
    // above 1023 is simply caught by the window compare.
    assign x_o   = {1'b0, base_x_i} + dx;
    assign y_o   = {1'b0, base_y_i} + dy;
    assign oor_o = (x_o < X_MIN) || (x_o > X_MAX) || (y_o < Y_MIN) || (y_o > Y_MAX);

endmodule

// File: rtl/collision_probe.sv
// collision_probe
// Probes six points around a player box against a tile map through a single
// query port and reports collision / ground / hazard / goal flags.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request a probe sequence (honoured only when idle)
//   px, py              : player box top-left, latched on accepted start
//   qx, qy, q_en        : registered tile-map query address and valid
//   qdata               : tile code for qx/qy, same cycle
//   busy, done          : sequence active / one-cycle completion pulse
//   hit_*, grounded,
//   hazard, goal        : result flags, updated only when a sequence ends
module collision_probe
    import collision_probe_pkg::*;
#(
    parameter int PW = 32,
    parameter int PH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic [9:0] qx,
    output logic [9:0] qy,
    output logic       q_en,
    input  logic [2:0] qdata,
    output logic       busy,
    output logic       done,
    output logic       hit_top,
    output logic       hit_bottom,
    output logic       hit_left,
    output logic       hit_right,
    output logic       grounded,
    output logic       hazard,
    output logic       goal
);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [9:0]  px_q, py_q;
    logic [9:0]  qx_q, qy_q;
    logic        oor_q;
    logic        q_en_q, busy_q, done_q;
    logic        hit_top_q, hit_bottom_q, hit_left_q, hit_right_q;
    logic        grounded_q, hazard_q, goal_q;

    // Per-probe results gathered during the sequence; probe 5 is consumed
    // directly at the final edge so it is never stored.
    logic [4:0]  solid_q;
    logic [3:0]  spike_q;
    logic [3:0]  goalt_q;

    // Next probe to present: in IDLE it is probe 0 of the incoming start
    // (taken straight from px/py), otherwise the one after idx_q.
    logic [9:0]  px_d, py_d;
    logic [2:0]  idx_d;
    logic [10:0] pp_x, pp_y;
    logic        pp_oor;
    logic        unused_msb;

    tile_t       cur_tile;
    logic        cur_solid;
    logic [5:0]  solid_all;

    always_comb begin
        px_d  = px_q;
        py_d  = py_q;
        idx_d = idx_q + 3'd1;
        if (state_q == ST_IDLE) begin
            px_d  = px;
            py_d  = py;
            idx_d = 3'd0;
        end
    end

    probe_point #(
        .PW(PW),
        .PH(PH)
    ) u_probe_point (
        .base_x_i (px_d),
        .base_y_i (py_d),
        .idx_i    (idx_d),
        .x_o      (pp_x),
        .y_o      (pp_y),
        .oor_o    (pp_oor)
    );

    // Bit 10 only matters for the out-of-range decision made inside probe_point.
    assign unused_msb = pp_x[10] ^ pp_y[10];

    assign cur_tile  = decode_tile(qdata, oor_q);
    assign cur_solid = (cur_tile == TILE_SOLID);
    assign solid_all = {cur_solid, solid_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            qx_q         <= '0;
            qy_q         <= '0;
            oor_q        <= 1'b0;
            q_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            solid_q      <= '0;
            spike_q      <= '0;
            goalt_q      <= '0;
            hit_top_q    <= 1'b0;
            hit_bottom_q <= 1'b0;
            hit_left_q   <= 1'b0;
            hit_right_q  <= 1'b0;
            grounded_q   <= 1'b0;
            hazard_q     <= 1'b0;
            goal_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        px_q    <= px;
                        py_q    <= py;
                        idx_q   <= 3'd0;
                        qx_q    <= pp_x[9:0];
                        qy_q    <= pp_y[9:0];
                        oor_q   <= pp_oor;
                        q_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        solid_q <= '0;
                        spike_q <= '0;
                        goalt_q <= '0;
                        state_q <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (idx_q == LAST_IDX) begin
                        hit_top_q    <= solid_all[0] | solid_all[1];
                        hit_bottom_q <= solid_all[2] | solid_all[3];
                        hit_left_q   <= solid_all[0] | solid_all[2];
                        hit_right_q  <= solid_all[1] | solid_all[3];
                        grounded_q   <= solid_all[4] | solid_all[5];
                        hazard_q     <= |spike_q;
                        goal_q       <= |goalt_q;
                        q_en_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        solid_q[idx_q] <= cur_solid;
                        // Foot probes (4,5) only contribute to grounded
                        if (idx_q < 3'd4) begin
                            spike_q[idx_q[1:0]] <= (cur_tile == TILE_SPIKE);
                            goalt_q[idx_q[1:0]] <= (cur_tile == TILE_GOAL);
                        end
                        idx_q <= idx_d;
                        qx_q  <= pp_x[9:0];
                        qy_q  <= pp_y[9:0];
                        oor_q <= pp_oor;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    q_en_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign qx         = qx_q;
    assign qy         = qy_q;
    assign q_en       = q_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_top    = hit_top_q;
    assign hit_bottom = hit_bottom_q;
    assign hit_left   = hit_left_q;
    assign hit_right  = hit_right_q;
    assign grounded   = grounded_q;
    assign hazard     = hazard_q;
    assign goal       = goal_q;

endmodule

// File: tb/tb_collision_probe.sv
module tb_collision_probe;

    localparam int PW = 32;
    localparam int PH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic [9:0] qx, qy;
    logic       q_en;
    logic [2:0] qdata;
    logic       busy, done;
    logic       hit_top, hit_bottom, hit_left, hit_right, grounded, hazard, goal;

    int n_cmp = 0;
    int n_err = 0;

    // Tile map: 15 rows x 20 columns of 32x32 tiles starting at (144,35)
    int tile_map [15][20];

    always #5 clk = ~clk;

    collision_probe #(.PW(PW), .PH(PH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .px         (px),
        .py         (py),
        .qx         (qx),
        .qy         (qy),
        .q_en       (q_en),
        .qdata      (qdata),
        .busy       (busy),
        .done       (done),
        .hit_top    (hit_top),
        .hit_bottom (hit_bottom),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .grounded   (grounded),
        .hazard     (hazard),
        .goal       (goal)
    );

    // Tile-map memory answering the query port combinationally; addresses
    // outside the field answer EMPTY so the DUT must force SOLID itself.
    always_comb begin
        qdata = 3'd0;
        if (qx >= 10'd144 && qx <= 10'd783 && qy >= 10'd35 && qy <= 10'd514)
            qdata = 3'(tile_map[(int'(qy) - 35) / 32][(int'(qx) - 144) / 32]);
    end

    function automatic logic [6:0] obs_flags();
        return {hit_top, hit_bottom, hit_left, hit_right, grounded, hazard, goal};
    endfunction

    // ---------------- reference model ----------------
    function automatic int probe_x(int bx, int k);
        return (k % 2 == 1) ? bx + PW - 1 : bx;
    endfunction

    function automatic int probe_y(int by, int k);
        if (k < 2) return by;
        if (k < 4) return by + PH - 1;
        return by + PH;
    endfunction

    function automatic int probe_code(int x, int y);
        int c;
        if (x < 144 || x > 783 || y < 35 || y > 514) return 1;
        c = tile_map[(y - 35) / 32][(x - 144) / 32];
        return (c > 3) ? 0 : c;
    endfunction

    // {top, bottom, left, right, grounded, hazard, goal}
    function automatic logic [6:0] model_flags(int bx, int by);
        int c [6];
        logic [6:0] f;
        for (int k = 0; k < 6; k++) c[k] = probe_code(probe_x(bx, k), probe_y(by, k));
        f[6] = (c[0] == 1) || (c[1] == 1);
        f[5] = (c[2] == 1) || (c[3] == 1);
        f[4] = (c[0] == 1) || (c[2] == 1);
        f[3] = (c[1] == 1) || (c[3] == 1);
        f[2] = (c[4] == 1) || (c[5] == 1);
        f[1] = (c[0] == 2) || (c[1] == 2) || (c[2] == 2) || (c[3] == 2);
        f[0] = (c[0] == 3) || (c[1] == 3) || (c[2] == 3) || (c[3] == 3);
        return f;
    endfunction

    task automatic clear_map();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++) tile_map[r][c] = 0;
    endtask

    // One complete sequence, checked cycle by cycle; returns observed flags.
    task automatic run_seq(input int bx, input int by, input string tag, output logic [6:0] got);
        logic [6:0] exp_f;
        logic [6:0] old_f;
        exp_f = model_flags(bx, by);
        old_f = obs_flags();
        @(negedge clk);
        start = 1'b1; px = 10'(bx); py = 10'(by);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (q_en !== 1'b1 || qx !== 10'(probe_x(bx, k)) || qy !== 10'(probe_y(by, k)) ||
                busy !== 1'b1 || done !== 1'b0 || obs_flags() !== old_f) begin
                n_err++;
                $display("FAIL %s probe%0d: got qen=%b qx=%0d qy=%0d busy=%b done=%b flags=%b, want qen=1 qx=%0d qy=%0d busy=1 done=0 flags=%b",
                         tag, k, q_en, qx, qy, busy, done, obs_flags(),
                         10'(probe_x(bx, k)), 10'(probe_y(by, k)), old_f);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1 || q_en !== 1'b0 || obs_flags() !== exp_f ||
            qx !== 10'(probe_x(bx, 5)) || qy !== 10'(probe_y(by, 5))) begin
            n_err++;
            $display("FAIL %s done-edge: got done=%b busy=%b qen=%b flags=%b qx=%0d qy=%0d, want done=1 busy=1 qen=0 flags=%b (held qx/qy)",
                     tag, done, busy, q_en, obs_flags(), qx, qy, exp_f);
        end
        got = obs_flags();
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || q_en !== 1'b0 || obs_flags() !== exp_f) begin
            n_err++;
            $display("FAIL %s idle-return: got done=%b busy=%b qen=%b flags=%b, want 0 0 0 %b",
                     tag, done, busy, q_en, obs_flags(), exp_f);
        end
        $display("seq %-10s px=%0d py=%0d flags(t,b,l,r,g,h,goal)=%b", tag, bx, by, got);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || q_en !== 1'b0 || qx !== 10'd0 || qy !== 10'd0 || obs_flags() !== 7'd0) begin
            n_err++;
            $display("FAIL reset: got busy=%b done=%b qen=%b qx=%0d qy=%0d flags=%b, want all 0",
                     busy, done, q_en, qx, qy, obs_flags());
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_empty();
        logic [6:0] f;
        clear_map();
        run_seq(176, 67, "empty", f);
        n_cmp++;
        if (f !== 7'b0000000) begin
            n_err++;
            $display("FAIL empty_flags: got %b want 0000000", f);
        end
    endtask

    task automatic test_grounded();
        logic [6:0] f;
        clear_map();
        tile_map[3][1] = 1;
        run_seq(176, 99, "grounded", f);
        n_cmp++;
        if (f !== 7'b0000100) begin
            n_err++;
            $display("FAIL grounded_flags: got %b want 0000100", f);
        end
    endtask

    task automatic test_left_edge();
        logic [6:0] f;
        clear_map();
        run_seq(140, 67, "left_edge", f);
        n_cmp++;
        if (f[6] !== 1'b1 || f[5] !== 1'b1 || f[4] !== 1'b1 || f[3] !== 1'b0) begin
            n_err++;
            $display("FAIL left_edge_flags: got %b want top=1 bottom=1 left=1 right=0", f);
        end
    endtask

    task automatic test_spike_goal();
        logic [6:0] f;
        clear_map();
        tile_map[1][2] = 2;   // contains TR (211,70)
        tile_map[2][1] = 3;   // contains BL (180,101)
        run_seq(180, 70, "spike_goal", f);
        n_cmp++;
        if (f !== 7'b0000011) begin
            n_err++;
            $display("FAIL spike_goal_flags: got %b want 0000011", f);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] f;
        clear_map();
        @(negedge clk);
        start = 1'b1; px = 10'd176; py = 10'd67;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);   // probe 2 sampled at the third edge
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || q_en !== 1'b0 || done !== 1'b0 || obs_flags() !== 7'd0 || qx !== 10'd0 || qy !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b qen=%b done=%b flags=%b qx=%0d qy=%0d, want all 0",
                     busy, q_en, done, obs_flags(), qx, qy);
        end
        $display("reset_mid asserted busy=%b q_en=%b flags=%b", busy, q_en, obs_flags());
        @(negedge clk);
        rst = 1'b0;
        tile_map[0][0] = 1;   // TL (150,40) solid
        run_seq(150, 40, "after_rst", f);
    endtask

    task automatic test_back_to_back();
        int nx;
        int dcount;
        clear_map();
        @(negedge clk);
        start = 1'b1; px = 10'd200; py = 10'd100;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (q_en !== 1'b1 || qx !== 10'(probe_x(200, k)) || qy !== 10'(probe_y(100, k))) begin
                n_err++;
                $display("FAIL hold_start probe%0d: got qen=%b qx=%0d qy=%0d, want qen=1 qx=%0d qy=%0d",
                         k, q_en, qx, qy, 10'(probe_x(200, k)), 10'(probe_y(100, k)));
            end
            px = 10'($urandom_range(300, 600));
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL hold_start done: got done=%b busy=%b want 1 1", done, busy);
        end
        nx = int'(px);
        @(posedge clk); #1;   // back to IDLE with start still high
        n_cmp++;
        if (busy !== 1'b0 || q_en !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL hold_start idle_gap: got busy=%b qen=%b done=%b want 0 0 0", busy, q_en, done);
        end
        @(posedge clk); #1;   // second sequence accepted here
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || q_en !== 1'b1 || qx !== 10'(nx) || qy !== 10'd100) begin
            n_err++;
            $display("FAIL hold_start restart: got busy=%b qen=%b qx=%0d qy=%0d want 1 1 %0d 100",
                     busy, q_en, qx, qy, nx);
        end
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        n_cmp++;
        if (dcount != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_start second_seq: got done_pulses=%0d busy=%b want 1 0", dcount, busy);
        end
        $display("back_to_back first px=200 second px=%0d", nx);
    endtask

    task automatic test_random();
        logic [6:0] f;
        int bx, by;
        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 20; c++)
                    tile_map[r][c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            if (n % 5 == 0) begin
                bx = int'($urandom_range(0, 1023));
                by = int'($urandom_range(0, 1023));
            end else begin
                bx = int'($urandom_range(120, 790));
                by = int'($urandom_range(20, 520));
            end
            run_seq(bx, by, $sformatf("rand%0d", n), f);
        end
    endtask

    initial begin
        clear_map();
        test_reset();
        test_empty();
        test_grounded();
        test_left_edge();
        test_reset_mid();
        test_spike_goal();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
